// File: rtl/div_pkg.sv
// Shared types, defaults and two's-complement helpers for the sequential signed divider.
package div_pkg;

   localparam int unsigned DIV_DEFAULT_WIDTH = 8;
   localparam int unsigned DIV_MAX_WIDTH     = 64;
   localparam int unsigned DIV_IDX_W         = $clog2(DIV_MAX_WIDTH);

   typedef logic [DIV_MAX_WIDTH-1:0] div_word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_e;

   // Low bits of the result are exact for any width up to DIV_MAX_WIDTH.
   function automatic div_word_t div_neg_if(input div_word_t x, input logic neg);
      return neg ? (~x + div_word_t'(1)) : x;
   endfunction

   // x holds a w-bit two's-complement value in its low bits (upper bits ignored).
   function automatic div_word_t div_abs(input div_word_t x, input int unsigned w);
      return div_neg_if(x, x[DIV_IDX_W'(w - 1)]);
   endfunction

endpackage

// File: rtl/div_substep.sv
// One restoring shift-subtract step: produces the next partial remainder and quotient bit.
module div_substep
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] prem,
   input  logic             dbit,
   input  logic [WIDTH-1:0] dmag,
   output logic [WIDTH-1:0] rem_c,
   output logic             qbit_c
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // One extra bit keeps the borrow visible even when the divisor magnitude is 2^(WIDTH-1).
   always_comb begin
      shifted = {prem, dbit};
      diff    = shifted - {1'b0, dmag};
      qbit_c  = ~diff[WIDTH];
      rem_c   = qbit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider, one quotient bit per clock, start/busy/done handshake.
// Optional `overflow` output enabled by defining DIV_OVERFLOW_FLAG_EN.
module seq_signed_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
`ifdef DIV_OVERFLOW_FLAG_EN
   output logic             overflow,
`endif
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] prem_q;
   logic [WIDTH-1:0] dmag_q;
   logic [WIDTH-1:0] smag_q;
   logic [WIDTH-1:0] dividend_q;
   logic             sign_n_q;
   logic             sign_d_q;
   logic             zero_q;
`ifdef DIV_OVERFLOW_FLAG_EN
   logic             ovf_q;
`endif

   logic [WIDTH-1:0] rem_c;
   logic             qbit_c;

   div_substep #(.WIDTH(WIDTH)) u_step (
      .prem   (prem_q),
      .dbit   (dmag_q[WIDTH-1]),
      .dmag   (smag_q),
      .rem_c  (rem_c),
      .qbit_c (qbit_c)
   );

   // dmag_q starts as |dividend| and fills with quotient bits as it shifts out.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prem_q      <= '0;
         dmag_q      <= '0;
         smag_q      <= '0;
         dividend_q  <= '0;
         sign_n_q    <= 1'b0;
         sign_d_q    <= 1'b0;
         zero_q      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef DIV_OVERFLOW_FLAG_EN
         ovf_q       <= 1'b0;
         overflow    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= CALC;
                  busy       <= 1'b1;
                  cnt_q      <= CNT_W'(WIDTH);
                  prem_q     <= '0;
                  dmag_q     <= WIDTH'(div_abs(div_word_t'(dividend), WIDTH));
                  smag_q     <= WIDTH'(div_abs(div_word_t'(divisor), WIDTH));
                  dividend_q <= dividend;
                  sign_n_q   <= dividend[WIDTH-1];
                  sign_d_q   <= divisor[WIDTH-1];
                  zero_q     <= (divisor == '0);
`ifdef DIV_OVERFLOW_FLAG_EN
                  ovf_q      <= (dividend == (WIDTH'(1) << (WIDTH - 1))) && (&divisor);
`endif
               end
            end
            CALC: begin
               prem_q <= rem_c;
               dmag_q <= {dmag_q[WIDTH-2:0], qbit_c};
               cnt_q  <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quotient    <= zero_q ? '1
                                     : WIDTH'(div_neg_if(div_word_t'(dmag_q), sign_n_q ^ sign_d_q));
               remainder   <= zero_q ? dividend_q
                                     : WIDTH'(div_neg_if(div_word_t'(prem_q), sign_n_q));
               div_by_zero <= zero_q;
`ifdef DIV_OVERFLOW_FLAG_EN
               overflow    <= ovf_q;
`endif
               done        <= 1'b1;
               busy        <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
